aes_block_serializer: RTL and testbench



---
 rtl/aes_block_serializer_if.sv | 37 +++
 rtl/aes_block_serializer.sv | 86 ++++++++
 tb/tb_aes_block_serializer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_serializer_if.sv
// Block-in / word-out stream bundle for aes_block_serializer.
// The out_last signal exists only when AES_SER_LAST_EN is defined.
interface aes_block_serializer_if #(
  parameter int DATA_W = 128,
  parameter int WORD_W = 32
);
  localparam int NWORDS = DATA_W / WORD_W;
  localparam int IDX_W  = $clog2(NWORDS);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic [IDX_W-1:0]  word_idx;
  logic              busy;
`ifdef AES_SER_LAST_EN
  logic              out_last;
`endif

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, word_idx, busy
`ifdef AES_SER_LAST_EN
    , input out_last
`endif
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, word_idx, busy
`ifdef AES_SER_LAST_EN
    , output out_last
`endif
  );
endinterface

// File: rtl/aes_block_serializer.sv
// Drains one DATA_W AES block into NWORDS WORD_W words over a valid/ready stream.
// Define AES_SER_LAST_EN to add the out_last marker on the final word of each block.
module aes_block_serializer #(
  parameter int DATA_W    = 128,
  parameter int WORD_W    = 32,
  parameter int MSW_FIRST = 1
) (
  input logic                   clk,
  input logic                   reset_n,
  aes_block_serializer_if.slave bus
);
  localparam int NWORDS = DATA_W / WORD_W;
  localparam int IDX_W  = $clog2(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] data_q;
  logic              valid_q;
  logic              last_word;

  function automatic logic [WORD_W-1:0] word_of(input logic [DATA_W-1:0] blk,
                                                input logic [IDX_W-1:0]  i);
    int                base;
    logic [DATA_W-1:0] shifted;
    base    = (MSW_FIRST != 0) ? DATA_W - (int'(i) + 1) * WORD_W : int'(i) * WORD_W;
    shifted = blk >> base;
    return shifted[WORD_W-1:0];
  endfunction

  assign last_word = (idx == LAST_IDX);

  // A new block may be taken while the last word of the current one is being handed off.
  assign bus.in_ready  = reset_n && ((state == IDLE) ||
                                     ((state == SEND) && last_word && bus.out_ready));
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.word_idx  = idx;
  assign bus.busy      = (state == SEND);
`ifdef AES_SER_LAST_EN
  assign bus.out_last  = valid_q && last_word;
`endif

  // The next word is preloaded into data_q on every handshake so out_data is always a register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      hold    <= '0;
      idx     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            hold    <= bus.in_data;
            idx     <= '0;
            data_q  <= word_of(bus.in_data, IDX_W'(0));
            valid_q <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (!last_word) begin
              idx    <= idx + IDX_W'(1);
              data_q <= word_of(hold, idx + IDX_W'(1));
            end else if (bus.in_valid) begin
              hold   <= bus.in_data;
              idx    <= '0;
              data_q <= word_of(bus.in_data, IDX_W'(0));
            end else begin
              idx     <= '0;
              data_q  <= '0;
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_block_serializer.sv
// Self-checking bench: MSW-first and LSW-first serializers driven in lockstep,
// constant vector table plus scoreboard queues checked on every word handshake.
module tb_aes_block_serializer;
  localparam int DATA_W = 128;
  localparam int WORD_W = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  typedef struct {
    logic [127:0] blk;
    logic [31:0]  words [4];
    int           stall_at;
    int           stall_len;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         out_ready = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t q_m[$];
  exp_t q_l[$];
  exp_t em, el;
  vec_t vecs [4];

  aes_block_serializer_if #(.DATA_W(DATA_W), .WORD_W(WORD_W)) bus_m ();
  aes_block_serializer_if #(.DATA_W(DATA_W), .WORD_W(WORD_W)) bus_l ();

  assign bus_m.in_valid  = in_valid;
  assign bus_m.in_data   = in_data;
  assign bus_m.out_ready = out_ready;
  assign bus_l.in_valid  = in_valid;
  assign bus_l.in_data   = in_data;
  assign bus_l.out_ready = out_ready;

  aes_block_serializer #(.DATA_W(DATA_W), .WORD_W(WORD_W), .MSW_FIRST(1)) dut_m (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_m)
  );

  aes_block_serializer #(.DATA_W(DATA_W), .WORD_W(WORD_W), .MSW_FIRST(0)) dut_l (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_l)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushBlock(input logic [31:0] w [4]);
    for (int k = 0; k < 4; k++) begin
      q_m.push_back('{data: w[k],     idx: 2'(k), last: (k == 3)});
      q_l.push_back('{data: w[3 - k], idx: 2'(k), last: (k == 3)});
    end
  endtask

  // Drive a block and wait (bounded) for it to be accepted; returns 1 ns after the accept edge.
  task automatic applyStimulus(input logic [127:0] blk, input logic [31:0] w [4]);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = blk;
    #1;
    while (!bus_m.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("accept_in_ready", bus_m.in_ready, 1);
    pushBlock(w);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drainBlock(input logic [31:0] w [4], input int stall_at, input int stall_len);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          checkOutput("stall_valid", bus_m.out_valid, 1);
          checkOutput("stall_data", bus_m.out_data, w[k]);
          checkOutput("stall_idx", bus_m.word_idx, k);
          checkOutput("stall_in_ready", bus_m.in_ready, 0);
`ifdef AES_SER_LAST_EN
          checkOutput("stall_last", bus_m.out_last, k == 3);
`endif
          @(posedge clk); #1;
        end
      end
      out_ready = 1'b1;
      #1;
      checkOutput("drain_valid", bus_m.out_valid, 1);
      checkOutput("drain_data", bus_m.out_data, w[k]);
      checkOutput("drain_in_ready", bus_m.in_ready, k == 3);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    #1;
    checkOutput("done_busy", bus_m.busy, 0);
    checkOutput("done_valid", bus_m.out_valid, 0);
    checkOutput("done_in_ready", bus_m.in_ready, 1);
  endtask

  // Scoreboard: every word handshake on either DUT pops and compares one expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus_m.out_valid && bus_m.out_ready) begin
        checkOutput("sb_m_pending", 128'(q_m.size() != 0), 1);
        if (q_m.size() != 0) begin
          em = q_m.pop_front();
          checkOutput("sb_m_data", bus_m.out_data, em.data);
          checkOutput("sb_m_idx", bus_m.word_idx, em.idx);
`ifdef AES_SER_LAST_EN
          checkOutput("sb_m_last", bus_m.out_last, em.last);
`endif
        end
      end
      if (bus_l.out_valid && bus_l.out_ready) begin
        checkOutput("sb_l_pending", 128'(q_l.size() != 0), 1);
        if (q_l.size() != 0) begin
          el = q_l.pop_front();
          checkOutput("sb_l_data", bus_l.out_data, el.data);
          checkOutput("sb_l_idx", bus_l.word_idx, el.idx);
`ifdef AES_SER_LAST_EN
          checkOutput("sb_l_last", bus_l.out_last, el.last);
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{blk: 128'h00112233_44556677_8899AABB_CCDDEEFF,
                words: '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF},
                stall_at: -1, stall_len: 0};
    vecs[1] = '{blk: 128'h00112233_44556677_8899AABB_CCDDEEFF,
                words: '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF},
                stall_at: 1, stall_len: 3};
    vecs[2] = '{blk: 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                words: '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210},
                stall_at: 3, stall_len: 2};
    vecs[3] = '{blk: 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678,
                words: '{32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678},
                stall_at: 0, stall_len: 1};

    #3;
    checkOutput("rst_out_valid", bus_m.out_valid, 0);
    checkOutput("rst_out_data", bus_m.out_data, 0);
    checkOutput("rst_word_idx", bus_m.word_idx, 0);
    checkOutput("rst_busy", bus_m.busy, 0);
    checkOutput("rst_in_ready", bus_m.in_ready, 0);
`ifdef AES_SER_LAST_EN
    checkOutput("rst_out_last", bus_m.out_last, 0);
`endif
    #9;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_in_ready", bus_m.in_ready, 1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].blk, vecs[i].words);
      drainBlock(vecs[i].words, vecs[i].stall_at, vecs[i].stall_len);
    end

    // Back-to-back: the second block is offered during the last-word handshake.
    applyStimulus(vecs[0].blk, vecs[0].words);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) begin
        in_valid = 1'b1;
        in_data  = vecs[2].blk;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checkOutput("b2b_valid", bus_m.out_valid, 1);
      checkOutput("b2b_in_ready", bus_m.in_ready, (c % 4) == 3);
      if (c == 3) pushBlock(vecs[2].words);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("b2b_done_busy", bus_m.busy, 0);

    // Reset between clock edges after the third word has been handed off.
    applyStimulus(vecs[3].blk, vecs[3].words);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    q_m.delete();
    q_l.delete();
    #1;
    checkOutput("mid_rst_valid", bus_m.out_valid, 0);
    checkOutput("mid_rst_data", bus_m.out_data, 0);
    checkOutput("mid_rst_busy", bus_m.busy, 0);
    checkOutput("mid_rst_l_valid", bus_l.out_valid, 0);
    @(negedge clk); #2;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("post_rst_valid", bus_m.out_valid, 0);
      checkOutput("post_rst_busy", bus_m.busy, 0);
    end
    out_ready = 1'b0;

    applyStimulus(vecs[1].blk, vecs[1].words);
    drainBlock(vecs[1].words, -1, 0);

    @(posedge clk); #1;
    checkOutput("sb_drained", q_m.size() + q_l.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
